// File: rtl/serial_argmax_chunk_sequencer_pkg.sv
// Shared definitions for the serial 16-lane argmax datapath: lane geometry,
// sequencer state encoding and the default-width chunk element type.
package serial_argmax_chunk_sequencer_pkg;

    // Lanes per chunk and the bits needed to address a lane inside a chunk.
    localparam int CHUNK_LANES = 16;
    localparam int LANE_IDX_W  = 4;

    // Sequencer state encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t ST_IDLE   = 2'd0;
    localparam seq_state_t ST_CLEAR  = 2'd1;
    localparam seq_state_t ST_STREAM = 2'd2;
    localparam seq_state_t ST_DONE   = 2'd3;

    // Chunk element at the default element width; the argmax consumer uses
    // the same type so both sides agree on signedness.
    localparam int DEFAULT_ELEM_WIDTH = 8;
    typedef logic signed [DEFAULT_ELEM_WIDTH-1:0] chunk_elem_t;

endpackage

// File: rtl/serial_argmax_chunk_sequencer.sv
// Producer for the serial argmax: captures a whole signed vector on start,
// clears the downstream accumulator for one cycle, streams the vector as
// ascending 16-lane chunks under valid/ready, then pulses done.
module serial_argmax_chunk_sequencer
    import serial_argmax_chunk_sequencer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int INDEX_WIDTH = 8,
    localparam int N           = 2 ** INDEX_WIDTH,
    localparam int NUM_CHUNKS  = N / CHUNK_LANES,
    localparam int CHUNK_IDX_W = INDEX_WIDTH - LANE_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [WIDTH-1:0]  in_vector [N],
    output logic                     busy,
    output logic                     clear_out,
    output logic signed [WIDTH-1:0]  chunk_out [CHUNK_LANES],
    output logic                     chunk_valid,
    input  logic                     chunk_ready,
    output logic [CHUNK_IDX_W-1:0]   chunk_index,
    output logic                     done
);

    localparam logic [CHUNK_IDX_W-1:0] LAST_CHUNK = CHUNK_IDX_W'(NUM_CHUNKS - 1);
    localparam logic [CHUNK_IDX_W-1:0] ZERO_CHUNK = {CHUNK_IDX_W{1'b0}};
    localparam logic [CHUNK_IDX_W-1:0] ONE_CHUNK  = CHUNK_IDX_W'(1);

    seq_state_t                r_state;
    logic [CHUNK_IDX_W-1:0]    r_chunk_index;
    logic signed [WIDTH-1:0]   r_buf [N];

    seq_state_t                w_state_next;
    logic [CHUNK_IDX_W-1:0]    w_chunk_index_next;
    logic                      w_capture;

    // A new vector is only taken when the sequencer is idle.
    assign w_capture = (r_state == ST_IDLE) && start;

    // Next-state and chunk counter logic; the last chunk never wraps the index.
    always_comb begin
        w_state_next       = r_state;
        w_chunk_index_next = r_chunk_index;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next       = ST_CLEAR;
                    w_chunk_index_next = ZERO_CHUNK;
                end else begin
                    w_state_next       = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (chunk_ready) begin
                    if (r_chunk_index == LAST_CHUNK) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_chunk_index_next = r_chunk_index + ONE_CHUNK;
                    end
                end else begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_DONE: begin
                w_state_next       = ST_IDLE;
                w_chunk_index_next = ZERO_CHUNK;
            end
            default: begin
                w_state_next       = ST_IDLE;
                w_chunk_index_next = ZERO_CHUNK;
            end
        endcase
    end

    // Control state; reset aborts any run in progress immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_chunk_index <= ZERO_CHUNK;
        end else begin
            r_state       <= w_state_next;
            r_chunk_index <= w_chunk_index_next;
        end
    end

    // Vector buffer; deliberately unreset, it is only read while streaming.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= in_vector;
        end
    end

    // Chunk mux: lane j shows element 16*chunk_index + j of the captured vector.
    for (genvar j = 0; j < CHUNK_LANES; j++) begin : g_lane
        assign chunk_out[j] = r_buf[{r_chunk_index, LANE_IDX_W'(j)}];
    end

    assign busy        = (r_state != ST_IDLE);
    assign clear_out   = (r_state == ST_CLEAR);
    assign chunk_valid = (r_state == ST_STREAM);
    assign done        = (r_state == ST_DONE);
    assign chunk_index = r_chunk_index;

endmodule

// File: tb/tb_serial_argmax_chunk_sequencer.sv
// Directed bench for serial_argmax_chunk_sequencer with a 64-element vector
// (4 chunks of 16 lanes). Cycle c is the clock period that ends at rising
// edge c; outputs are checked and inputs driven on the falling edge inside it.
module tb_serial_argmax_chunk_sequencer;
    import serial_argmax_chunk_sequencer_pkg::*;

    localparam int N  = 64;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        chunk_ready;
    chunk_elem_t in_vector [N];
    logic        busy;
    logic        clear_out;
    chunk_elem_t chunk_out [CHUNK_LANES];
    logic        chunk_valid;
    logic [1:0]  chunk_index;
    logic        done;

    chunk_elem_t golden [N];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    serial_argmax_chunk_sequencer #(.WIDTH(8), .INDEX_WIDTH(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_vector   (in_vector),
        .busy        (busy),
        .clear_out   (clear_out),
        .chunk_out   (chunk_out),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_index (chunk_index),
        .done        (done)
    );

    // Returns the first lane that differs from the expected chunk k, or -1.
    function automatic int first_bad_lane(input int k);
        for (int j = 0; j < CHUNK_LANES; j++) begin
            if (chunk_out[j] !== golden[16*k + j]) return j;
        end
        return -1;
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < N; i++) begin
            in_vector[i] = chunk_elem_t'(i - 32);
            golden[i]    = chunk_elem_t'(i - 32);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; chunk_ready = 1'b0;
        load_ramp();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (clear_out !== 1'b0)   begin n_fail++; $display("FAIL reset_clear got=%b exp=0", clear_out); end
        n_checks++; if (chunk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", chunk_valid); end
        n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (chunk_index !== 2'd0) begin n_fail++; $display("FAIL reset_index got=%0d exp=0", chunk_index); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lane0_tab [NC] = '{-32, -16, 0, 16};
        logic [3:0] exp_flags;
        int bad;
        load_ramp();
        for (int c = 0; c < 9; c++) begin
            exp_flags = {(c >= 1 && c <= 6), (c == 1), (c >= 2 && c <= 5), (c == 6)};
            n_checks++;
            if ({busy, clear_out, chunk_valid, done} !== exp_flags) begin
                n_fail++;
                $display("FAIL basic_flags cycle=%0d got=%b exp=%b", c, {busy, clear_out, chunk_valid, done}, exp_flags);
            end
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (chunk_index !== 2'(c - 2)) begin
                    n_fail++; $display("FAIL basic_index cycle=%0d got=%0d exp=%0d", c, chunk_index, c - 2);
                end
                n_checks++;
                if (int'(chunk_out[0]) != lane0_tab[c-2]) begin
                    n_fail++; $display("FAIL basic_lane0 cycle=%0d got=%0d exp=%0d", c, chunk_out[0], lane0_tab[c-2]);
                end
                bad = first_bad_lane(c - 2);
                n_checks++;
                if (bad != -1) begin
                    n_fail++; $display("FAIL basic_data cycle=%0d lane=%0d got=%0d exp=%0d", c, bad, chunk_out[bad], golden[16*(c-2)+bad]);
                end
            end
            if (c >= 7) begin
                n_checks++;
                if (chunk_index !== 2'd0) begin
                    n_fail++; $display("FAIL basic_idle_index cycle=%0d got=%0d exp=0", c, chunk_index);
                end
            end
            start = (c == 0); chunk_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int idx_tab [10] = '{-1, -1, 0, 1, 1, 1, 2, 3, -1, -1};
        logic [3:0] exp_flags;
        int xfers = 0;
        int bad;
        load_ramp();
        for (int c = 0; c < 10; c++) begin
            exp_flags = {(c >= 1 && c <= 8), (c == 1), (idx_tab[c] >= 0), (c == 8)};
            n_checks++;
            if ({busy, clear_out, chunk_valid, done} !== exp_flags) begin
                n_fail++;
                $display("FAIL stall_flags cycle=%0d got=%b exp=%b", c, {busy, clear_out, chunk_valid, done}, exp_flags);
            end
            if (idx_tab[c] >= 0) begin
                n_checks++;
                if (chunk_index !== 2'(idx_tab[c])) begin
                    n_fail++; $display("FAIL stall_index cycle=%0d got=%0d exp=%0d", c, chunk_index, idx_tab[c]);
                end
                bad = first_bad_lane(idx_tab[c]);
                n_checks++;
                if (bad != -1) begin
                    n_fail++; $display("FAIL stall_data cycle=%0d lane=%0d got=%0d exp=%0d", c, bad, chunk_out[bad], golden[16*idx_tab[c]+bad]);
                end
            end
            start = (c == 0); chunk_ready = !(c == 3 || c == 4);
            if (chunk_valid && chunk_ready) xfers++;
            @(negedge clk);
        end
        n_checks++;
        if (xfers != 4) begin n_fail++; $display("FAIL stall_transfers got=%0d exp=4", xfers); end
    endtask

    task automatic test_start_ignored();
        int clears = 0;
        logic [2:0] exp_flags;
        load_ramp();
        for (int c = 0; c < 10; c++) begin
            exp_flags = {(c >= 1 && c <= 6), (c >= 2 && c <= 5), (c == 6)};
            n_checks++;
            if ({busy, chunk_valid, done} !== exp_flags) begin
                n_fail++; $display("FAIL ignore_flags cycle=%0d got=%b exp=%b", c, {busy, chunk_valid, done}, exp_flags);
            end
            if (clear_out === 1'b1) clears++;
            start = (c == 0 || c == 3 || c == 6); chunk_ready = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (clears != 1) begin n_fail++; $display("FAIL ignore_clears got=%0d exp=1", clears); end
    endtask

    task automatic test_vector_hold();
        int bad;
        load_ramp();
        for (int c = 0; c < 8; c++) begin
            if (c >= 2 && c <= 5) begin
                bad = first_bad_lane(c - 2);
                n_checks++;
                if (bad != -1) begin
                    n_fail++; $display("FAIL hold_data cycle=%0d lane=%0d got=%0d exp=%0d", c, bad, chunk_out[bad], golden[16*(c-2)+bad]);
                end
            end
            start = (c == 0); chunk_ready = 1'b1;
            if (c == 2) begin
                for (int i = 0; i < N; i++) in_vector[i] = 8'sh7F;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        int bad_cycles = 0;
        load_ramp();
        for (int c = 0; c < 4; c++) begin
            start = (c == 0); chunk_ready = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (chunk_valid !== 1'b1 || chunk_index !== 2'd2) begin
            n_fail++; $display("FAIL areset_pre got=%b/%0d exp=1/2", chunk_valid, chunk_index);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, chunk_valid, done} !== 3'b000) begin
            n_fail++; $display("FAIL areset_immediate got=%b exp=000", {busy, chunk_valid, done});
        end
        n_checks++;
        if (chunk_index !== 2'd0) begin n_fail++; $display("FAIL areset_index got=%0d exp=0", chunk_index); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (busy !== 1'b0 || chunk_valid !== 1'b0 || done !== 1'b0 || clear_out !== 1'b0) bad_cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (bad_cycles != 0) begin n_fail++; $display("FAIL areset_quiet got=%0d active cycles exp=0", bad_cycles); end
    endtask

    task automatic test_argmax();
        int best = 0;
        int best_idx = -1;
        bit seen_done = 1'b0;
        for (int i = 0; i < N; i++) in_vector[i] = -8'sd5;
        in_vector[37] = 8'sd100;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (done === 1'b1) begin
                seen_done = 1'b1;
                n_checks++;
                if (best != 100) begin n_fail++; $display("FAIL argmax_max got=%0d exp=100", best); end
                n_checks++;
                if (best_idx != 37) begin n_fail++; $display("FAIL argmax_index got=%0d exp=37", best_idx); end
                n_checks++;
                if (c != 7) begin n_fail++; $display("FAIL argmax_done_cycle got=%0d exp=7", c); end
            end
            start = (c == 0); chunk_ready = (c != 3);
            if (chunk_valid && chunk_ready) begin
                for (int j = 0; j < CHUNK_LANES; j++) begin
                    if (best_idx < 0 || int'(chunk_out[j]) > best) begin
                        best     = int'(chunk_out[j]);
                        best_idx = 16 * int'(chunk_index) + j;
                    end
                end
            end
            @(negedge clk);
        end
        if (!seen_done) begin
            n_checks++; n_fail++;
            $display("FAIL argmax_timeout got=no done exp=done within 20 cycles");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_vector_hold();
        test_async_reset();
        test_basic();
        test_argmax();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_argmax_chunk_sequencer.md
Name: serial_argmax_chunk_sequencer

Overview:
Producer side of the serial 16-lane argmax datapath. Captures a full 2**INDEX_WIDTH-element signed vector on a start request. Issues a one-cycle clear to the downstream serial argmax, then streams the vector as consecutive 16-lane chunks under a valid/ready handshake. Pulses done after the last chunk is accepted, so the downstream max/argmax can be sampled by the controller.

Parameters:
WIDTH, 8, bit width of each signed element
INDEX_WIDTH, 8, element index width; vector length N = 2**INDEX_WIDTH; INDEX_WIDTH >= 5 required (at least 2 chunks)
NUM_CHUNKS (localparam), N/16, chunks per vector; CHUNK_IDX_W = INDEX_WIDTH-4

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request to load in_vector and run; honoured only in IDLE
in_vector  in  [N][WIDTH] signed  full vector, sampled on the accepted start edge only
busy  out  1  high whenever state != IDLE
clear_out  out  1  one-cycle synchronous clear for the downstream argmax
chunk_out  out  [16][WIDTH] signed  current chunk; lane j = element 16*chunk_index + j
chunk_valid  out  1  chunk_out valid; drives downstream enable gated with chunk_ready
chunk_ready  in  1  downstream accepts the chunk this cycle
chunk_index  out  CHUNK_IDX_W  index of the chunk currently presented
done  out  1  one-cycle pulse after the final chunk is accepted

Behaviour:
- Reset (async assert, any state): state IDLE. busy=0, clear_out=0, chunk_valid=0, done=0, chunk_index=0. The vector buffer is not reset. chunk_out is don't-care while chunk_valid=0.
- States: IDLE, CLEAR, STREAM, DONE. All outputs come from registers or a mux of registers; there is no combinational path from any input to any output.
- IDLE: on start=1, register in_vector into the internal buffer, set chunk_index=0, go to CLEAR.
- CLEAR: clear_out=1 for exactly one cycle, then go to STREAM. chunk_valid=0 in this state.
- STREAM:
  - chunk_valid=1.
  - A transfer occurs when chunk_valid && chunk_ready.
  - On a transfer with chunk_index < NUM_CHUNKS-1, increment chunk_index.
  - On a transfer with chunk_index == NUM_CHUNKS-1, go to DONE. chunk_index is not incremented, so there is no wrap to 0.
  - chunk_ready=0 stalls: chunk_out and chunk_index hold, chunk_valid stays 1.
- DONE: done=1 for one cycle, chunk_valid=0, then go to IDLE. chunk_index returns to 0.
- start while not IDLE is ignored, including in the DONE cycle. in_vector changes during a run have no effect.
- Latency with chunk_ready held at 1, start sampled at edge 0:
  - clear_out high in cycle 1.
  - chunk k valid in cycle 2+k.
  - done in cycle 2+NUM_CHUNKS.
  - earliest new start accepted at edge 3+NUM_CHUNKS.
- Ordering contract: downstream argmax = 16*chunk_index + lane, so chunks must be issued strictly in ascending order.
- Reset asserted mid-STREAM aborts the run immediately. No done is pulsed, and no further chunk_valid appears.

Decomposition:
- Shared package: CHUNK_LANES=16, LANE_IDX_W=4, the state enum typedef, and the chunk element type (signed [WIDTH-1:0]), shared with the serial argmax.
- No sub-module. The FSM, the buffer and the chunk mux fit in one module.

Test Plan (INDEX_WIDTH=6, N=64, 4 chunks, WIDTH=8):
1. Element i = i-32, start pulse, ready always 1 -> clear_out in cycle 1; chunks 0..3 in cycles 2..5 with lane0 values -32,-16,0,16; done in cycle 6; busy high cycles 1..6.
2. Same vector, chunk_ready low in cycles 3-4 -> chunk 1 held for 3 cycles with unchanged data; done in cycle 8; total of exactly 4 transfers.
3. start re-pulsed in cycles 3 and 6 (DONE cycle) -> both ignored; no second clear_out; busy drops after cycle 6.
4. in_vector changed to all 0x7F in cycle 2 -> streamed chunks still carry the vector captured at start.
5. rst asserted mid-cycle in cycle 4 -> busy and chunk_valid fall immediately (async), done never pulses; a following start produces a normal full run.
6. Connected to the serial argmax, element 37 = +100 and all others -5 -> at done, downstream max=100 and argmax=37.
